// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined WIDTH-bit shifter (SLL/SRL/SRA/ROL).
// It has one register stage per shift-amount bit and a global stall enable.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_din,
  input  logic [SHW-1:0]   i_sel,
  input  logic [1:0]       i_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_zero
);
  logic             w_adv;
  logic [WIDTH-1:0] r_data [SHW];
  logic [WIDTH-1:0] w_data [SHW];
  logic [SHW-1:0]   r_sel  [SHW];
  logic [SHW-1:0]   w_sel  [SHW];
  logic [1:0]       r_mode [SHW];
  logic [1:0]       w_mode [SHW];
  logic             r_msb  [SHW];
  logic             w_msb  [SHW];
  logic             r_vld  [SHW];
  logic             w_vld  [SHW];

  assign w_adv       = !r_vld[SHW-1] || i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_vld[SHW-1];
  assign o_dout      = r_data[SHW-1];
  assign o_zero      = ~|r_data[SHW-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int S = 1 << k;
    logic [WIDTH-1:0] w_d;
    logic [SHW-1:0]   w_s;
    logic [1:0]       w_m;
    logic             w_x;
    logic             w_v;
    if (k == 0) begin : g_head
      assign {w_v, w_x, w_m, w_s, w_d} = {i_in_valid, i_din[WIDTH-1], i_mode, i_sel, i_din};
    end else begin : g_body
      assign {w_v, w_x, w_m, w_s, w_d} = {r_vld[k-1], r_msb[k-1], r_mode[k-1], r_sel[k-1], r_data[k-1]};
    end
    // The shift amount is consumed LSB-first, so each stage only ever looks at bit 0.
    assign w_sel[k]  = w_s >> 1;
    assign w_mode[k] = w_m;
    assign w_msb[k]  = w_x;
    assign w_vld[k]  = w_v;
    // Bubbles load zero so the output is 0 whenever the final valid bit is low.
    assign w_data[k] = !w_v ? '0 :
                       !w_s[0] ? w_d :
                       w_m == 2'd0 ? w_d << S :
                       w_m == 2'd1 ? w_d >> S :
                       w_m == 2'd2 ? (w_d >> S) | ({WIDTH{w_x}} << (WIDTH - S)) :
                       (w_d << S) | (w_d >> (WIDTH - S));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data <= '{default: '0};
      r_sel  <= '{default: '0};
      r_mode <= '{default: '0};
      r_msb  <= '{default: 1'b0};
      r_vld  <= '{default: 1'b0};
    end else if (w_adv) begin
      r_data <= w_data;
      r_sel  <= w_sel;
      r_mode <= w_mode;
      r_msb  <= w_msb;
      r_vld  <= w_vld;
    end
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and random checks of barrel_shifter_pipe
// at WIDTH 8, 16 and 32 against an arithmetic reference model.
module tb_barrel_shifter_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  iv, ordy, irdy, ov, z;
  logic [31:0] din  [3];
  logic [4:0]  sel  [3];
  logic [1:0]  mode [3];
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;

  logic [31:0] q0[$], q1[$], q2[$];
  logic [2:0]  s_ov, s_rdy, s_z;
  logic [31:0] s_d [3];
  int nvec = 0, nerr = 0;

  logic [7:0] t_din [8], t_sel [8], t_exp [8];
  logic [1:0] t_mode [8];

  barrel_shifter_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv[0]), .o_in_ready(irdy[0]),
    .i_din(din[0][7:0]), .i_sel(sel[0][2:0]), .i_mode(mode[0]),
    .o_out_valid(ov[0]), .i_out_ready(ordy[0]), .o_dout(d8), .o_zero(z[0]));
  barrel_shifter_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv[1]), .o_in_ready(irdy[1]),
    .i_din(din[1][15:0]), .i_sel(sel[1][3:0]), .i_mode(mode[1]),
    .o_out_valid(ov[1]), .i_out_ready(ordy[1]), .o_dout(d16), .o_zero(z[1]));
  barrel_shifter_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(iv[2]), .o_in_ready(irdy[2]),
    .i_din(din[2]), .i_sel(sel[2]), .i_mode(mode[2]),
    .o_out_valid(ov[2]), .i_out_ready(ordy[2]), .o_dout(d32), .o_zero(z[2]));

  function automatic logic [31:0] ref_shift(int w, logic [31:0] d, int s, logic [1:0] m);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & mask;
    case (m)
      2'd0: r = x << s;
      2'd1: r = x >> s;
      2'd2: r = (x >> s) | (x[w-1] ? mask & ~(mask >> s) : 64'd0);
      default: r = (x << s) | (x >> (w - s));
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int qsize(int i);
    return i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
  endfunction

  function automatic void qpush(int i, logic [31:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [31:0] qpop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples every instance at the falling edge, runs the scoreboard, then
  // returns 1 time unit after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(negedge clk);
    s_ov = ov; s_rdy = irdy; s_z = z;
    s_d[0] = 32'(d8); s_d[1] = 32'(d16); s_d[2] = d32;
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", 32'(s_rdy[i]), 32'(!s_ov[i] || ordy[i]));
      if (!s_ov[i]) begin
        chk("idle_dout", s_d[i], 32'd0);
        chk("idle_zero", 32'(s_z[i]), 32'd1);
      end else if (ordy[i]) begin
        chk("sb_nonempty", 32'(qsize(i) != 0), 32'd1);
        if (qsize(i) != 0) begin
          logic [31:0] e;
          e = qpop(i);
          chk("sb_dout", s_d[i], e);
          chk("sb_zero", 32'(s_z[i]), 32'(e == 0));
        end
      end
      if (iv[i] && s_rdy[i]) qpush(i, ref_shift(8 << i, din[i], int'(sel[i]), mode[i]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_tab(string tag, int n);
    for (int c = 0; c < n + 4; c++) begin
      iv[0] = c < n;
      if (c < n) begin
        din[0] = 32'(t_din[c]); sel[0] = t_sel[c][4:0]; mode[0] = t_mode[c];
      end
      cyc();
      chk({tag, "_valid"}, 32'(s_ov[0]), 32'(c >= 3 && c < n + 3));
      if (c >= 3 && c < n + 3) begin
        chk({tag, "_dout"}, s_d[0], 32'(t_exp[c-3]));
        chk({tag, "_zero"}, 32'(s_z[0]), 32'(t_exp[c-3] == 0));
      end
    end
  endtask

  initial begin
    logic [7:0]  sw [4] = '{8'hA8, 8'h16, 8'hF6, 8'hAD};
    logic [7:0]  bd [5];
    logic [31:0] bexp [5];
    int nxt, got, seen, ncyc;
    int acc [3];
    rst_n = 1'b0; iv = '0; ordy = '1;
    for (int i = 0; i < 3; i++) begin din[i] = '0; sel[i] = '0; mode[i] = '0; end
    repeat (3) cyc();
    chk("rst_valid", 32'(s_ov[0]), 32'd0);
    chk("rst_dout", s_d[0], 32'd0);
    chk("rst_zero", 32'(s_z[0]), 32'd1);
    chk("rst_ready", 32'(s_rdy[0]), 32'd1);
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("idle_valid", 32'(s_ov[0]), 32'd0);
    chk("idle_ready", 32'(s_rdy[0]), 32'd1);

    for (int m = 0; m < 4; m++) begin
      t_din[m] = 8'hB5; t_sel[m] = 8'd3; t_mode[m] = 2'(m); t_exp[m] = sw[m];
    end
    run_tab("sweep", 4);

    for (int m = 0; m < 4; m++) begin
      t_din[m] = 8'h5A; t_sel[m] = 8'd0; t_mode[m] = 2'(m); t_exp[m] = 8'h5A;
    end
    t_din[4] = 8'h80; t_sel[4] = 8'd1; t_mode[4] = 2'd0; t_exp[4] = 8'h00;
    t_din[5] = 8'h80; t_sel[5] = 8'd7; t_mode[5] = 2'd2; t_exp[5] = 8'hFF;
    t_din[6] = 8'h81; t_sel[6] = 8'd7; t_mode[6] = 2'd3; t_exp[6] = 8'hC0;
    run_tab("bound", 7);

    for (int b = 0; b < 5; b++) begin
      bd[b] = 8'h3C ^ 8'(b * 37);
      bexp[b] = ref_shift(8, 32'(bd[b]), (b * 3) % 8, 2'(b));
    end
    ordy[0] = 1'b0; nxt = 0;
    for (int c = 0; c < 7; c++) begin
      iv[0] = nxt < 5;
      if (nxt < 5) begin din[0] = 32'(bd[nxt]); sel[0] = 5'((nxt * 3) % 8); mode[0] = 2'(nxt); end
      cyc();
      if (iv[0] && s_rdy[0]) nxt++;
      if (c >= 3) begin
        chk("bp_stall_ready", 32'(s_rdy[0]), 32'd0);
        chk("bp_hold_valid", 32'(s_ov[0]), 32'd1);
        chk("bp_hold_dout", s_d[0], bexp[0]);
      end
    end
    chk("bp_held", 32'(nxt), 32'd3);
    ordy[0] = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      iv[0] = nxt < 5;
      if (nxt < 5) begin din[0] = 32'(bd[nxt]); sel[0] = 5'((nxt * 3) % 8); mode[0] = 2'(nxt); end
      cyc();
      if (iv[0] && s_rdy[0]) nxt++;
      if (s_ov[0]) begin chk("bp_order", s_d[0], bexp[got]); got++; end
    end
    chk("bp_count", 32'(got), 32'd5);
    iv[0] = 1'b0;
    cyc();
    chk("bp_ready", 32'(s_rdy[0]), 32'd1);
    chk("bp_drained", 32'(s_ov[0]), 32'd0);

    for (int c = 0; c < 3; c++) begin
      iv[0] = 1'b1; din[0] = 32'(8'hC3 + c); sel[0] = 5'(c + 1); mode[0] = 2'(c);
      cyc();
    end
    iv[0] = 1'b0;
    chk("mr_inflight", 32'(ov[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(ov[0]), 32'd0);
    chk("mr_dout", 32'(d8), 32'd0);
    chk("mr_ready", 32'(irdy[0]), 32'd1);
    q0.delete(); q1.delete(); q2.delete();
    repeat (2) cyc();
    rst_n = 1'b1; seen = 0;
    repeat (8) begin cyc(); seen += int'(s_ov[0]); end
    chk("mr_stale", 32'(seen), 32'd0);

    acc = '{0, 0, 0}; ncyc = 0;
    while (ncyc < 30000 && (acc[0] < 10000 || acc[1] < 10000 || acc[2] < 10000)) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = $urandom_range(0, 3) != 0;
        ordy[i] = $urandom_range(0, 3) != 0;
        din[i]  = $urandom & 32'((64'd1 << (8 << i)) - 64'd1);
        sel[i]  = 5'($urandom_range(0, (8 << i) - 1));
        mode[i] = 2'($urandom_range(0, 3));
      end
      cyc();
      for (int i = 0; i < 3; i++) if (iv[i] && s_rdy[i]) acc[i]++;
      ncyc++;
    end
    iv = '0; ordy = '1;
    for (int c = 0; c < 40 && (qsize(0) + qsize(1) + qsize(2)) != 0; c++) cyc();
    for (int i = 0; i < 3; i++) begin
      chk("rand_beats", 32'(acc[i] >= 10000), 32'd1);
      chk("rand_drain", 32'(qsize(i)), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
